// File: rtl/fast_pat_pkg.sv
// Shared types and constants for the fast pattern load/fetch paths.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fast_pat_pkg;
   localparam int PIX_W           = 24;
   localparam int WORD_W          = 256;
   localparam int GROUP_PIX       = 32;
   localparam int WORDS_PER_GROUP = 3;
   localparam int PACK_W          = PIX_W * GROUP_PIX;
   localparam int MEM_ADDR_W      = 13;
   localparam logic [7:0] TRIG_VALUE_DEF = 8'h77;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_WR0,
      ST_WR1,
      ST_WR2,
      ST_TRIG
   } pat_state_e;

   // Top bit of a pixel lane inside the packed group; lane 0 sits at the top.
   function automatic logic [9:0] lane_msb(input logic [4:0] lane);
      return 10'(PACK_W - 1 - PIX_W * int'(lane));
   endfunction
endpackage

// File: rtl/pat_pix_packer.sv
// Packs 32 pixels into a 768-bit group and exposes it as three 256-bit words.
// Latency: a pixel written on one edge is visible on word the next cycle.
// Backpressure: none; the caller decides when to write, clear and select.
module pat_pix_packer
   import fast_pat_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                clr,
   input  logic                wr_en,
   input  logic [4:0]          lane,
   input  logic [PIX_W-1:0]    pix,
   input  logic [1:0]          word_sel,
   output logic [WORD_W-1:0]   word
);
   logic [PACK_W-1:0] pack;
   logic [9:0]        msb;

   assign msb = lane_msb(lane);

   // Group register: clear zeroes every lane, so unfilled lanes read as zero
   // padding; a write in the same cycle as a clear still lands.
   always_ff @(posedge clk) begin
      if (rst) begin
         pack <= '0;
      end else begin
         if (clr)   pack <= '0;
         if (wr_en) pack[msb -: PIX_W] <= pix;
      end
   end

   // Word select: word 0 is the top third of the group.
   always_comb begin
      word = '0;
      case (word_sel)
         2'd0:    word = pack[PACK_W-1          -: WORD_W];
         2'd1:    word = pack[PACK_W-1-WORD_W   -: WORD_W];
         2'd2:    word = pack[PACK_W-1-2*WORD_W -: WORD_W];
         default: word = '0;
      endcase
   end
endmodule

// File: rtl/fast_pat_load.sv
// Loads a pixel frame into on-chip memory in fetch layout, then writes the start trigger.
// Latency: first write strobe the cycle after the 32nd pixel of a group is accepted.
// Backpressure: s_pix_ready=load_enable in IDLE/FILL, held low during the 3-word burst and trigger.
module fast_pat_load
   import fast_pat_pkg::*;
#(
   parameter int         PIX_PER_LINE = 80,
   parameter int         LINES        = 1080,
   parameter int         BASE_ADDR    = 1,
   parameter int         TRIG_ADDR    = 0,
   parameter logic [7:0] TRIG_VALUE   = TRIG_VALUE_DEF
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_enable,
   input  logic [PIX_W-1:0]      s_pix_data,
   input  logic                  s_pix_valid,
   output logic                  s_pix_ready,
   input  logic                  s_pix_sof,
   input  logic                  s_pix_last,
   output logic                  onchip_mem_chip_select,
   output logic                  onchip_mem_clk_ena,
   output logic                  onchip_mem_chip_read,
   output logic [MEM_ADDR_W-1:0] onchip_mem_addr,
   output logic [31:0]           onchip_mem_byte_enable,
   output logic [WORD_W-1:0]     onchip_mem_write_data,
   output logic                  onchip_mem_write,
   output logic                  load_busy,
   output logic                  load_done,
   output logic                  frame_err
);
   localparam logic [16:0]           TOTAL = 17'(PIX_PER_LINE * LINES);
   localparam logic [MEM_ADDR_W-1:0] BASE  = MEM_ADDR_W'(BASE_ADDR);
   localparam logic [MEM_ADDR_W-1:0] TRIG  = MEM_ADDR_W'(TRIG_ADDR);

   generate
      if ((PIX_PER_LINE * LINES) % GROUP_PIX != 0) begin : g_bad_frame_size
         $error("fast_pat_load: PIX_PER_LINE*LINES must be a multiple of 32");
      end
   endgenerate

   pat_state_e            state, state_nxt;
   logic [16:0]           pix_cnt, pix_cnt_nxt, cnt_inc;
   logic [4:0]            grp_cnt, grp_cnt_nxt;
   logic [MEM_ADDR_W-1:0] addr, addr_nxt;
   logic                  early, early_nxt;
   logic                  err, err_nxt;
   logic                  run_q, done_q;
   logic                  acc, restart, store, pk_clr;
   logic [1:0]            word_sel;
   logic [WORD_W-1:0]     pk_word;

   pat_pix_packer u_packer (
      .clk      (clk),
      .rst      (rst),
      .clr      (pk_clr),
      .wr_en    (restart | store),
      .lane     (restart ? 5'd0 : grp_cnt),
      .pix      (s_pix_data),
      .word_sel (word_sel),
      .word     (pk_word)
   );

   // State, counters and status flags; run_q keeps clk_ena and ready low in reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         pix_cnt <= '0;
         grp_cnt <= '0;
         addr    <= BASE;
         early   <= 1'b0;
         err     <= 1'b0;
         run_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state   <= state_nxt;
         pix_cnt <= pix_cnt_nxt;
         grp_cnt <= grp_cnt_nxt;
         addr    <= addr_nxt;
         early   <= early_nxt;
         err     <= err_nxt;
         run_q   <= 1'b1;
         done_q  <= (state == ST_TRIG);
      end
   end

   // Next-state, pixel accounting and memory port drive.
   always_comb begin
      state_nxt              = state;
      pix_cnt_nxt            = pix_cnt;
      grp_cnt_nxt            = grp_cnt;
      addr_nxt               = addr;
      early_nxt              = early;
      err_nxt                = err;
      cnt_inc                = '0;
      s_pix_ready            = 1'b0;
      acc                    = 1'b0;
      restart                = 1'b0;
      store                  = 1'b0;
      pk_clr                 = 1'b0;
      word_sel               = 2'd0;
      onchip_mem_write       = 1'b0;
      onchip_mem_addr        = '0;
      onchip_mem_byte_enable = '0;
      onchip_mem_write_data  = '0;

      case (state)
         ST_IDLE: begin
            s_pix_ready = load_enable & run_q;
            acc         = s_pix_valid & s_pix_ready;
            // Beats before a start-of-frame are consumed and ignored.
            if (acc && s_pix_sof) begin
               restart = 1'b1;
               err_nxt = 1'b0;
            end
         end
         ST_FILL: begin
            s_pix_ready = load_enable & run_q;
            acc         = s_pix_valid & s_pix_ready;
            if (acc) begin
               if (s_pix_sof) begin
                  // Restarted frame: drop the partial group and flag it.
                  restart = 1'b1;
                  err_nxt = 1'b1;
               end else begin
                  store = 1'b1;
               end
            end
         end
         ST_WR0: begin
            onchip_mem_write       = 1'b1;
            onchip_mem_addr        = addr;
            onchip_mem_byte_enable = '1;
            word_sel               = 2'd0;
            onchip_mem_write_data  = pk_word;
            state_nxt              = ST_WR1;
         end
         ST_WR1: begin
            onchip_mem_write       = 1'b1;
            onchip_mem_addr        = addr + MEM_ADDR_W'(1);
            onchip_mem_byte_enable = '1;
            word_sel               = 2'd1;
            onchip_mem_write_data  = pk_word;
            state_nxt              = ST_WR2;
         end
         ST_WR2: begin
            onchip_mem_write       = 1'b1;
            onchip_mem_addr        = addr + MEM_ADDR_W'(2);
            onchip_mem_byte_enable = '1;
            word_sel               = 2'd2;
            onchip_mem_write_data  = pk_word;
            addr_nxt               = addr + MEM_ADDR_W'(WORDS_PER_GROUP);
            pk_clr                 = 1'b1;
            if (early) begin
               // Truncated frame: no trigger, the fetch side must not start.
               state_nxt   = ST_IDLE;
               early_nxt   = 1'b0;
               pix_cnt_nxt = '0;
               grp_cnt_nxt = '0;
               addr_nxt    = BASE;
            end else if (pix_cnt == TOTAL) begin
               state_nxt = ST_TRIG;
            end else begin
               state_nxt = ST_FILL;
            end
         end
         ST_TRIG: begin
            onchip_mem_write       = 1'b1;
            onchip_mem_addr        = TRIG;
            onchip_mem_byte_enable = 32'h1;
            onchip_mem_write_data  = {{(WORD_W-8){1'b0}}, TRIG_VALUE};
            state_nxt              = ST_IDLE;
            addr_nxt               = BASE;
            pix_cnt_nxt            = '0;
            grp_cnt_nxt            = '0;
         end
         default: state_nxt = ST_IDLE;
      endcase

      // Shared bookkeeping for every pixel that lands in the group register.
      if (restart || store) begin
         cnt_inc     = restart ? 17'd1 : pix_cnt + 17'd1;
         pix_cnt_nxt = cnt_inc;
         grp_cnt_nxt = restart ? 5'd1 : grp_cnt + 5'd1;
         early_nxt   = 1'b0;
         if (restart) addr_nxt = BASE;
         if (cnt_inc == TOTAL) begin
            if (!s_pix_last) err_nxt = 1'b1;
            state_nxt = ST_WR0;
         end else if (s_pix_last) begin
            early_nxt = 1'b1;
            err_nxt   = 1'b1;
            state_nxt = ST_WR0;
         end else if (!restart && grp_cnt == 5'd31) begin
            state_nxt = ST_WR0;
         end else begin
            state_nxt = ST_FILL;
         end
      end
   end

   assign onchip_mem_chip_select = onchip_mem_write;
   assign onchip_mem_clk_ena     = run_q;
   assign onchip_mem_chip_read   = 1'b0;
   assign load_busy              = (state != ST_IDLE);
   assign load_done              = done_q;
   assign frame_err              = err;
endmodule

// File: tb/tb_fast_pat_load.sv
module tb_fast_pat_load;
   import fast_pat_pkg::*;

   localparam int PPL = 32;
   localparam int LN  = 2;
   localparam int TOT = PPL * LN;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          load_enable = 1'b0;
   logic [23:0]   s_pix_data = '0;
   logic          s_pix_valid = 1'b0;
   logic          s_pix_ready;
   logic          s_pix_sof = 1'b0;
   logic          s_pix_last = 1'b0;
   logic          cs, clk_ena, rd, wr, busy, done, err;
   logic [12:0]   maddr;
   logic [31:0]   be;
   logic [255:0]  wdata;

   always #5 clk = ~clk;

   fast_pat_load #(.PIX_PER_LINE(PPL), .LINES(LN)) dut (
      .clk                    (clk),
      .rst                    (rst),
      .load_enable            (load_enable),
      .s_pix_data             (s_pix_data),
      .s_pix_valid            (s_pix_valid),
      .s_pix_ready            (s_pix_ready),
      .s_pix_sof              (s_pix_sof),
      .s_pix_last             (s_pix_last),
      .onchip_mem_chip_select (cs),
      .onchip_mem_clk_ena     (clk_ena),
      .onchip_mem_chip_read   (rd),
      .onchip_mem_addr        (maddr),
      .onchip_mem_byte_enable (be),
      .onchip_mem_write_data  (wdata),
      .onchip_mem_write       (wr),
      .load_busy              (busy),
      .load_done              (done),
      .frame_err              (err)
   );

   typedef struct packed {
      logic [12:0]  addr;
      logic [255:0] data;
      logic [31:0]  be;
   } wr_t;

   typedef struct {
      logic [12:0] addr;
      logic [31:0] be;
      logic [23:0] top;
      logic [7:0]  low;
   } vec_t;

   wr_t  got_q[$];
   wr_t  exp_q[$];
   vec_t tbl[7];

   int n_cmp = 0;
   int n_bad = 0;
   int done_cnt = 0;
   int rdy_viol = 0;
   bit rand_mode = 0;

   // Reference model state: frame-level view of the pixel stream.
   logic [23:0] m_buf[$];
   bit          m_active;
   int          m_n;
   int          m_done = 0;
   logic [12:0] m_addr;
   logic        m_err;

   // Observe the memory port and handshake away from the rising edge.
   always @(negedge clk) begin
      if (wr) got_q.push_back('{maddr, wdata, be});
      if (done) done_cnt++;
      if (wr && s_pix_ready) rdy_viol++;
   end

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   function automatic void m_reset();
      m_buf.delete();
      m_active = 0;
      m_n      = 0;
      m_addr   = 13'd1;
      m_err    = 1'b0;
   endfunction

   function automatic void m_emit();
      logic [767:0] g;
      g = '0;
      for (int i = 0; i < m_buf.size(); i++) g[767 - 24*i -: 24] = m_buf[i];
      exp_q.push_back('{m_addr,         g[767:512], 32'hFFFF_FFFF});
      exp_q.push_back('{m_addr + 13'd1, g[511:256], 32'hFFFF_FFFF});
      exp_q.push_back('{m_addr + 13'd2, g[255:0],   32'hFFFF_FFFF});
      m_addr = m_addr + 13'd3;
      m_buf.delete();
   endfunction

   function automatic void m_beat(input logic [23:0] d, input logic sof, input logic last);
      if (sof) begin
         m_err    = m_active ? 1'b1 : 1'b0;
         m_active = 1;
         m_buf.delete();
         m_n      = 0;
         m_addr   = 13'd1;
      end else if (!m_active) begin
         return;
      end
      m_buf.push_back(d);
      m_n++;
      if (m_n == TOT || last || m_buf.size() == 32) begin
         m_emit();
         if (m_n == TOT) begin
            if (!last) m_err = 1'b1;
            exp_q.push_back('{13'd0, {248'h0, 8'h77}, 32'h1});
            m_done++;
            m_active = 0;
         end else if (last) begin
            m_err    = 1'b1;
            m_active = 0;
         end
      end
   endfunction

   task automatic send(input logic [23:0] d, input logic sof, input logic last);
      int waitc = 0;
      if (rand_mode) repeat ($urandom_range(0, 2)) @(negedge clk);
      @(negedge clk);
      s_pix_data  = d;
      s_pix_sof   = sof;
      s_pix_last  = last;
      s_pix_valid = 1'b1;
      if (rand_mode) load_enable = ($urandom_range(0, 3) != 0);
      #1;
      while (!s_pix_ready) begin
         waitc++;
         if (waitc > 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: ready still 0 after 200 cycles, required 1");
            s_pix_valid = 1'b0;
            load_enable = 1'b1;
            return;
         end
         @(negedge clk);
         if (rand_mode) load_enable = ($urandom_range(0, 3) != 0);
         #1;
      end
      @(posedge clk);
      m_beat(d, sof, last);
      #1;
      s_pix_valid = 1'b0;
      s_pix_sof   = 1'b0;
      s_pix_last  = 1'b0;
   endtask

   task automatic wait_idle(input string nm);
      int c = 0;
      @(negedge clk);
      while (busy && c < 100) begin
         @(negedge clk);
         c++;
      end
      chk({nm, "_idle"}, 256'(busy), 256'(0));
      repeat (3) @(negedge clk);
   endtask

   task automatic cmp_writes(input string nm);
      chk({nm, "_wcount"}, 256'(got_q.size()), 256'(exp_q.size()));
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         chk($sformatf("%s_w%0d_addr", nm, i), 256'(got_q[i].addr), 256'(exp_q[i].addr));
         chk($sformatf("%s_w%0d_data", nm, i), got_q[i].data, exp_q[i].data);
         chk($sformatf("%s_w%0d_be", nm, i), 256'(got_q[i].be), 256'(exp_q[i].be));
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic chk_reset_outputs(input string nm);
      chk({nm, "_ready"}, 256'(s_pix_ready), 256'(0));
      chk({nm, "_wr"},    256'(wr),          256'(0));
      chk({nm, "_cs"},    256'(cs),          256'(0));
      chk({nm, "_clken"}, 256'(clk_ena),     256'(0));
      chk({nm, "_rd"},    256'(rd),          256'(0));
      chk({nm, "_addr"},  256'(maddr),       256'(0));
      chk({nm, "_be"},    256'(be),          256'(0));
      chk({nm, "_data"},  wdata,             256'(0));
      chk({nm, "_busy"},  256'(busy),        256'(0));
      chk({nm, "_done"},  256'(done),        256'(0));
      chk({nm, "_err"},   256'(err),         256'(0));
   endtask

   initial begin
      logic [23:0] pix;
      logic [23:0] sof_pix;
      int          a0;

      // Hand-derived layout of the 1..64 ramp frame: word top 24 bits and low byte.
      tbl[0] = '{13'd1, 32'hFFFF_FFFF, 24'h000001, 8'h00};
      tbl[1] = '{13'd2, 32'hFFFF_FFFF, 24'h0B0000, 8'h00};
      tbl[2] = '{13'd3, 32'hFFFF_FFFF, 24'h001600, 8'h20};
      tbl[3] = '{13'd4, 32'hFFFF_FFFF, 24'h000021, 8'h00};
      tbl[4] = '{13'd5, 32'hFFFF_FFFF, 24'h2B0000, 8'h00};
      tbl[5] = '{13'd6, 32'hFFFF_FFFF, 24'h003600, 8'h40};
      tbl[6] = '{13'd0, 32'h0000_0001, 24'h000000, 8'h77};

      m_reset();
      repeat (2) @(posedge clk);
      #1;
      chk_reset_outputs("rst0");
      @(negedge clk);
      rst = 1'b0;
      load_enable = 1'b1;
      @(posedge clk);
      #1;
      chk("clk_ena_after_rst", 256'(clk_ena), 256'(1));

      // Ramp frame, no gaps.
      for (int p = 1; p <= TOT; p++) begin
         send(24'(p), p == 1, p == TOT);
         if (p == 32) begin
            chk("lat_first_wr", 256'(wr), 256'(1));
            chk("lat_first_addr", 256'(maddr), 256'(1));
         end
      end
      wait_idle("ramp");
      for (int i = 0; i < 7; i++) begin
         if (i < got_q.size()) begin
            chk($sformatf("tbl%0d_addr", i), 256'(got_q[i].addr), 256'(tbl[i].addr));
            chk($sformatf("tbl%0d_be", i), 256'(got_q[i].be), 256'(tbl[i].be));
            chk($sformatf("tbl%0d_top", i), 256'(got_q[i].data[255:232]), 256'(tbl[i].top));
            chk($sformatf("tbl%0d_low", i), 256'(got_q[i].data[7:0]), 256'(tbl[i].low));
         end
      end
      cmp_writes("ramp");
      chk("ramp_done", 256'(done_cnt), 256'(1));
      chk("ramp_err", 256'(err), 256'(0));

      // Same ramp with random gaps and load_enable toggling.
      rand_mode = 1;
      for (int p = 1; p <= TOT; p++) send(24'(p), p == 1, p == TOT);
      rand_mode = 0;
      load_enable = 1'b1;
      wait_idle("gaps");
      cmp_writes("gaps");
      chk("gaps_done", 256'(done_cnt), 256'(m_done));
      chk("gaps_err", 256'(err), 256'(m_err));

      // Early last at pixel 40.
      for (int p = 1; p <= 40; p++) send(24'($urandom), p == 1, p == 40);
      wait_idle("early");
      a0 = 0;
      foreach (got_q[i]) if (got_q[i].addr == 13'd0) a0++;
      chk("early_no_trig", 256'(a0), 256'(0));
      if (got_q.size() == 6) begin
         chk("early_pad_w4", 256'(got_q[3].data[63:0]), 256'(0));
         chk("early_pad_w5", got_q[4].data, 256'(0));
         chk("early_pad_w6", got_q[5].data, 256'(0));
      end
      cmp_writes("early");
      chk("early_err", 256'(err), 256'(1));
      chk("early_done", 256'(done_cnt), 256'(m_done));

      // sof reasserted at pixel 20, then a complete frame follows from it.
      for (int p = 1; p <= 19; p++) send(24'($urandom), p == 1, 1'b0);
      sof_pix = 24'hABCDE5;
      send(sof_pix, 1'b1, 1'b0);
      for (int p = 2; p <= TOT; p++) send(24'($urandom), 1'b0, p == TOT);
      wait_idle("resof");
      if (got_q.size() > 0) begin
         chk("resof_first_addr", 256'(got_q[0].addr), 256'(1));
         chk("resof_lane0", 256'(got_q[0].data[255:232]), 256'(sof_pix));
      end
      cmp_writes("resof");
      chk("resof_err", 256'(err), 256'(1));
      chk("resof_done", 256'(done_cnt), 256'(m_done));

      // Beats without sof in IDLE are swallowed, then a clean frame.
      for (int p = 0; p < 5; p++) send(24'($urandom), 1'b0, p == 4);
      repeat (4) @(negedge clk);
      chk("drop_no_writes", 256'(got_q.size()), 256'(0));
      for (int p = 1; p <= TOT; p++) send(24'($urandom), p == 1, p == TOT);
      wait_idle("drop");
      cmp_writes("drop");
      chk("drop_err", 256'(err), 256'(0));
      chk("drop_done", 256'(done_cnt), 256'(m_done));

      // Reset while the burst is on its second word.
      for (int p = 1; p <= 32; p++) send(24'($urandom), p == 1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("rstwr_in_wr1", 256'(maddr), 256'(2));
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk_reset_outputs("rstwr");
      @(negedge clk);
      rst = 1'b0;
      m_reset();
      got_q.delete();
      exp_q.delete();
      repeat (2) @(negedge clk);
      chk("rstwr_no_trig", 256'(got_q.size()), 256'(0));
      for (int p = 1; p <= TOT; p++) begin
         pix = 24'($urandom);
         send(pix, p == 1, p == TOT);
      end
      wait_idle("after_rst");
      cmp_writes("after_rst");
      chk("after_rst_done", 256'(done_cnt), 256'(m_done));
      chk("after_rst_err", 256'(err), 256'(0));

      chk("ready_low_during_writes", 256'(rdy_viol), 256'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
